ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the single-port SPI-style RAM (10-bit command word {cmd[1:0], payload[7:0]}) between NUM_REQ requesters.
//  Converts each requester transaction into the RAM command sequence and returns the result on a per-requester response.
//  Sits between the SPI slave / local host masters and the RAM, in place of a direct rx_data/rx_valid hookup.
// PARAMETERS
//  NUM_REQ     2   number of requesters; index 0 is highest priority after reset
//  WORD_W      8   address and data width; RAM command word is WORD_W+2
//  RD_TIMEOUT  15  WAIT_RD cycles allowed for ram_tx_valid before an error response
// PORTS
//  clk           in   1               single clock, all logic on posedge
//  rst_n         in   1               synchronous, active-low reset
//  req_valid     in   NUM_REQ         per-requester request strobe; held until accepted
//  req_write     in   NUM_REQ         1 = write, 0 = read
//  req_addr      in   NUM_REQ*WORD_W  packed addresses; slice i belongs to requester i
//  req_wdata     in   NUM_REQ*WORD_W  packed write data
//  req_ready     out  NUM_REQ         accept; a transfer happens when req_valid[i] & req_ready[i]
//  rsp_valid     out  NUM_REQ         one-cycle completion pulse to the owning requester
//  rsp_rdata     out  WORD_W          read data, valid with rsp_valid
//  rsp_err       out  1               read timeout, valid with rsp_valid
//  ram_din       out  WORD_W+2        RAM command word
//  ram_rx_valid  out  1               RAM command strobe
//  ram_dout      in   WORD_W          RAM read data
//  ram_tx_valid  in   1               RAM read data strobe
// BEHAVIOUR
//  Reset: all outputs are 0; state = IDLE; wait counter = 0; last_grant = NUM_REQ-1.
//  Reset mid-operation: the transaction is abandoned with no rsp_valid.
//  All outputs except req_ready are registered. req_ready is combinational: one-hot, only in IDLE.
//  FSM states: IDLE -> WR_ADDR -> WR_DATA -> RESP; IDLE -> RD_ADDR -> RD_CMD -> WAIT_RD -> RESP.
//  IDLE
//   - Round-robin over req_valid: the search starts at last_grant+1 and wraps.
//   - The winner g sees req_ready[g]=1. On the accept edge: latch g, write, addr and wdata;
//     update last_grant; go to WR_ADDR or RD_ADDR.
//   - Dropping req_valid before acceptance is legal. No grant is issued when no request is valid.
//  WR_ADDR:  ram_din={2'b00,addr}, ram_rx_valid=1.
//  WR_DATA:  ram_din={2'b01,wdata}, ram_rx_valid=1.
//  RD_ADDR:  ram_din={2'b10,addr}, ram_rx_valid=1.
//  RD_CMD:   ram_din={2'b11,0}, ram_rx_valid=1. The wait counter clears on exit.
//  ram_din is 0 whenever ram_rx_valid=0. Exactly one command is issued per cycle, with no gaps.
//  WAIT_RD
//   - ram_tx_valid=1: capture ram_dout and go to RESP with err=0.
//   - Otherwise the counter increments; at count==RD_TIMEOUT-1: go to RESP with err=1, rdata=0.
//   - If tx_valid arrives in the timeout cycle, the data wins (err=0).
//  RESP: rsp_valid[g]=1 for one cycle with rsp_rdata/rsp_err (0 and 0 for writes); then IDLE.
//   rsp_rdata and rsp_err return to 0 after the pulse.
//  Latency from the accept edge T:
//   - write: commands at T+1 and T+2; rsp_valid at T+3
//   - read: commands at T+1 and T+2; rsp_valid one cycle after ram_tx_valid
//   - next accept earliest the cycle after RESP
//  ram_tx_valid outside WAIT_RD is ignored. req_* is not sampled outside IDLE.
//  Counter width is $clog2(RD_TIMEOUT+1).
// STRUCTURE
//  Package ram_arb_pkg:
//   - CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//   - typedef enum arb_state_e {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, WAIT_RD, RESP}
//  Sub-module rr_arbiter #(NUM_REQ): req vector + last_grant + enable -> one-hot grant + index.
//  FSM, latches, counter and response logic stay in this module.
// TESTING
//  1. rst_n=0 for 3 cycles with req_valid=2'b11
//     -> req_ready=0, ram_rx_valid=0, ram_din=0, rsp_valid=0 throughout.
//  2. Req0 writes addr 8'h2A, data 8'hC3
//     -> ram_din=10'h02A at T+1, 10'h1C3 at T+2; rsp_valid=2'b01 at T+3 with rsp_err=0.
//  3. Req1 reads addr 8'h2A
//     -> ram_din=10'h22A then 10'h300; rsp_valid=2'b10 with rsp_rdata=8'hC3, rsp_err=0.
//  4. Both requesters hold req_valid continuously after reset -> grants alternate 0,1,0,1; none starved.
//  5. Read with the RAM model's tx_valid suppressed
//     -> rsp_valid after RD_TIMEOUT cycles in WAIT_RD, rsp_err=1, rsp_rdata=0.
//  6. rst_n=0 for one cycle during WAIT_RD
//     -> no rsp_valid, state IDLE; the following write/read to 8'h05 completes normally.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// Shared command codes, FSM state type and sizing helper for the RAM access arbiter.
package ram_arb_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, WAIT_RD, RESP
  } arb_state_e;

  // Index width for a requester select; never zero so a single requester still has a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester and RAM-side bus of the arbiter; slave = arbiter, master = requesters plus RAM.
interface ram_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_addr;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [WORD_W-1:0]              rsp_rdata;
  logic                           rsp_err;
  logic [WORD_W+1:0]              ram_din;
  logic                           ram_rx_valid;
  logic [WORD_W-1:0]              ram_dout;
  logic                           ram_tx_valid;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_access_arbiter_rr.sv
// Combinational round-robin pick: search starts one past last_grant and wraps.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);
  localparam logic [IW:0] N = (IW+1)'(NUM_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_grant} + (IW+1)'(off);
      if (sum >= N) sum = sum - N;
      cand = sum[IW-1:0];
      if (en && !any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one SPI-style RAM between NUM_REQ requesters, turning each transaction
// into its two-command RAM sequence and returning a one-cycle response.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input logic     clk,
  input logic     rst_n,
  ram_arb_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  arb_state_e         state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gidx;
  logic [WORD_W-1:0]  wdata_q;
  logic [CW-1:0]      cnt;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] g_oh;
  logic [IW-1:0]      win_idx;
  logic               win;

  // Ready is held low during reset as well, so no accept can be seen on the release edge.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .en         (rst_n && (state == IDLE)),
    .grant      (grant),
    .grant_idx  (win_idx),
    .any        (win)
  );

  assign bus.req_ready = grant;
  assign g_oh          = NUM_REQ'(1) << gidx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= IW'(NUM_REQ - 1);
      gidx             <= '0;
      wdata_q          <= '0;
      cnt              <= '0;
      bus.ram_din      <= '0;
      bus.ram_rx_valid <= 1'b0;
      bus.rsp_valid    <= '0;
      bus.rsp_rdata    <= '0;
      bus.rsp_err      <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: if (win) begin
          gidx             <= win_idx;
          last_grant       <= win_idx;
          wdata_q          <= bus.req_wdata[win_idx];
          bus.ram_rx_valid <= 1'b1;
          if (bus.req_write[win_idx]) begin
            bus.ram_din <= {CMD_WR_ADDR, bus.req_addr[win_idx]};
            state       <= WR_ADDR;
          end else begin
            bus.ram_din <= {CMD_RD_ADDR, bus.req_addr[win_idx]};
            state       <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          bus.ram_din <= {CMD_WR_DATA, wdata_q};
          state       <= WR_DATA;
        end
        WR_DATA: begin
          bus.ram_din      <= '0;
          bus.ram_rx_valid <= 1'b0;
          bus.rsp_valid    <= g_oh;
          bus.rsp_rdata    <= '0;
          bus.rsp_err      <= 1'b0;
          state            <= RESP;
        end
        RD_ADDR: begin
          bus.ram_din <= {CMD_RD_DATA, WORD_W'(0)};
          state       <= RD_CMD;
        end
        RD_CMD: begin
          bus.ram_din      <= '0;
          bus.ram_rx_valid <= 1'b0;
          cnt              <= '0;
          state            <= WAIT_RD;
        end
        // Data arriving in the final timeout cycle still beats the error.
        WAIT_RD: begin
          if (bus.ram_tx_valid) begin
            bus.rsp_valid <= g_oh;
            bus.rsp_rdata <= bus.ram_dout;
            bus.rsp_err   <= 1'b0;
            state         <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.rsp_valid <= g_oh;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural SPI-RAM on the bus.
module tb_ram_access_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int WORD_W     = 8;
  localparam int RD_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   suppress = 1'b0;

  always #5 clk = ~clk;

  ram_arb_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

  ram_access_arbiter #(
    .NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // RAM model: address latched by either address command, read data one cycle after RD_DATA.
  logic [7:0] mem [256];
  logic [7:0] ram_a = 8'h00;

  always @(posedge clk) begin
    bus.ram_tx_valid <= 1'b0;
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00, 2'b10: ram_a <= bus.ram_din[7:0];
        2'b01:        mem[ram_a] <= bus.ram_din[7:0];
        default: begin
          bus.ram_tx_valid <= !suppress;
          bus.ram_dout     <= mem[ram_a];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives one request and checks the whole command/response sequence.
  task automatic txn(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit exp_err, input int exp_wait);
    bit got = 1'b0;
    int k;
    logic [1:0] oh;
    oh = 2'(1 << r);
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = wr;
    bus.req_addr[r]  = a;
    bus.req_wdata[r] = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready == oh) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("grant", 32'(got), 32'd1);
    if (!got) begin bus.req_valid[r] = 1'b0; return; end
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    check("cmd1", {bus.ram_rx_valid, bus.ram_din}, wr ? {1'b1, 2'b00, a} : {1'b1, 2'b10, a});
    check("rdy_busy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("cmd2", {bus.ram_rx_valid, bus.ram_din}, wr ? {1'b1, 2'b01, d} : {1'b1, 2'b11, 8'h00});
    k = 0;
    do begin @(negedge clk); k++; end while (bus.rsp_valid == '0 && k < 40);
    check("rsp_lat", 32'(k), 32'(exp_wait));
    check("rsp_vld", 32'(bus.rsp_valid), 32'(oh));
    check("rsp_data", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rd});
    check("rsp_cmd_idle", {bus.ram_rx_valid, bus.ram_din}, 32'd0);
    @(negedge clk);
    check("rsp_clear", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [4];
    int ng;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.ram_dout     = '0;
    bus.ram_tx_valid = 1'b0;
    rst_n            = 1'b0;
    bus.req_valid    = 2'b11;
    bus.req_write    = 2'b11;
    bus.req_addr[0]  = 8'h10;
    bus.req_addr[1]  = 8'h11;
    bus.req_wdata[0] = 8'hA0;
    bus.req_wdata[1] = 8'hA1;

    // Reset with both requests pending
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_cmd", {bus.ram_rx_valid, bus.ram_din}, 32'd0);
      check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'd0);
    end

    // Both held continuously: grants must alternate starting at requester 0
    rst_n = 1'b1;
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      #1;
      if (bus.req_ready != '0) begin seq[ng] = bus.req_ready; ng++; end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    check("rr_count", 32'(ng), 32'd4);
    check("rr_g0", 32'(seq[0]), 32'h1);
    check("rr_g1", 32'(seq[1]), 32'h2);
    check("rr_g2", 32'(seq[2]), 32'h1);
    check("rr_g3", 32'(seq[3]), 32'h2);
    repeat (6) @(negedge clk);

    txn(0, 1'b1, 8'h2A, 8'hC3, 8'h00, 1'b0, 1);
    txn(1, 1'b0, 8'h2A, 8'h00, 8'hC3, 1'b0, 2);
    txn(0, 1'b0, 8'h11, 8'h00, 8'hA1, 1'b0, 2);

    // RAM never answers: timeout after RD_TIMEOUT cycles in WAIT_RD
    suppress = 1'b1;
    txn(0, 1'b0, 8'h2A, 8'h00, 8'h00, 1'b1, RD_TIMEOUT + 1);

    // Reset pulse while waiting for read data
    bus.req_valid[1] = 1'b1;
    bus.req_write[1] = 1'b0;
    bus.req_addr[1]  = 8'h2A;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready == 2'b10) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_grant", 32'(seen), 32'd1);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_out", {bus.rsp_valid, bus.ram_rx_valid, bus.ram_din}, 32'd0);
    rst_n    = 1'b1;
    suppress = 1'b0;
    seen     = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    txn(0, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0, 1);
    txn(1, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
